// File: rtl/core_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_bus_pkg
// Description : Shared op encodings, initiator state type and helpers for the
//               core-side memory bus initiator.
// Revision    : 1.0 - initial release
// ============================================================================
package core_bus_pkg;

    localparam logic [1:0] OP_DRAM_RD = 2'b00;
    localparam logic [1:0] OP_DRAM_WR = 2'b01;
    localparam logic [1:0] OP_DATA_RD = 2'b10;
    localparam logic [1:0] OP_DATA_WR = 2'b11;

    localparam int c_DEFAULT_TIMEOUT = 1024;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    function automatic logic op_is_data(input logic [1:0] op);
        return (op == OP_DATA_RD) || (op == OP_DATA_WR);
    endfunction

    function automatic logic op_is_write(input logic [1:0] op);
        return (op == OP_DRAM_WR) || (op == OP_DATA_WR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/core_bus_initiator_timeout_ctr.sv
`default_nettype none
// ============================================================================
// Module      : bus_timeout_ctr
// Description : Per-phase cycle counter with clear/enable and an expiry flag
//               for the bus initiator handshake watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_timeout_ctr #(
    parameter int TIMEOUT = 1024,
    parameter int CW      = 11
) (
    input  logic CLK,
    input  logic RST_X,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam logic [CW-1:0] c_LIMIT   = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic          c_ENABLED = (TIMEOUT > 0);

    logic [CW-1:0] r_count;

    always_ff @(posedge CLK) begin
        if (RST_X) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != c_LIMIT)) begin
            r_count <= r_count + 1'b1;
        end
    end

    // High on the edge that would make the count reach TIMEOUT.
    assign o_expired = c_ENABLED & i_enable & (r_count == c_LIMIT);

endmodule
`default_nettype wire

// File: rtl/core_bus_initiator.sv
`default_nettype none
// ============================================================================
// Module      : core_bus_initiator
// Description : Core-side master port for the shared multicore memory bus;
//               one DRAM or data operation at a time with busy handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module core_bus_initiator
    import core_bus_pkg::*;
#(
    parameter int TIMEOUT = c_DEFAULT_TIMEOUT,
    parameter int CW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
    input  logic        CLK,
    input  logic        RST_X,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_ctrl,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        bus_dram_le,
    output logic        bus_dram_we_t,
    output logic [31:0] bus_dram_addr,
    output logic [31:0] bus_dram_wdata,
    output logic [2:0]  bus_dram_ctrl,
    input  logic        bus_dram_busy,
    input  logic [31:0] bus_dram_odata,
    output logic        bus_data_le,
    output logic        bus_data_we,
    output logic [31:0] bus_mem_paddr,
    output logic [31:0] bus_data_wdata,
    input  logic [3:0]  bus_data_busy,
    input  logic [31:0] bus_data_data
);

    state_t      r_state;
    logic [1:0]  r_op;
    logic        r_dram_le;
    logic        r_dram_we;
    logic        r_data_le;
    logic        r_data_we;
    logic [31:0] r_dram_addr;
    logic [31:0] r_dram_wdata;
    logic [2:0]  r_dram_ctrl;
    logic [31:0] r_data_paddr;
    logic [31:0] r_data_wdata;
    logic        r_rsp_valid;
    logic        r_rsp_err;
    logic [31:0] r_rsp_rdata;

    logic w_req_ready;
    logic w_accept;
    logic w_sel_busy;
    logic w_ctr_clear;
    logic w_ctr_enable;
    logic w_expired;

    // Both sides must be quiet so a stale busy is never mistaken for an ack.
    assign w_req_ready  = (r_state == IDLE) && !bus_dram_busy && !(|bus_data_busy);
    assign w_accept     = req_valid && w_req_ready;
    assign w_sel_busy   = op_is_data(r_op) ? (|bus_data_busy) : bus_dram_busy;
    assign w_ctr_clear  = w_accept || ((r_state == ISSUE) && w_sel_busy);
    assign w_ctr_enable = (r_state == ISSUE) || (r_state == WAIT);

    bus_timeout_ctr #(
        .TIMEOUT (TIMEOUT),
        .CW      (CW)
    ) u_timeout_ctr (
        .CLK       (CLK),
        .RST_X     (RST_X),
        .i_clear   (w_ctr_clear),
        .i_enable  (w_ctr_enable),
        .o_expired (w_expired)
    );

    always_ff @(posedge CLK) begin
        if (RST_X) begin
            r_state      <= IDLE;
            r_op         <= OP_DRAM_RD;
            r_dram_le    <= 1'b0;
            r_dram_we    <= 1'b0;
            r_data_le    <= 1'b0;
            r_data_we    <= 1'b0;
            r_dram_addr  <= '0;
            r_dram_wdata <= '0;
            r_dram_ctrl  <= '0;
            r_data_paddr <= '0;
            r_data_wdata <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_err    <= 1'b0;
            r_rsp_rdata  <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_op    <= req_op;
                        r_state <= ISSUE;
                        if (op_is_data(req_op)) begin
                            r_data_paddr <= req_addr;
                            r_data_wdata <= req_wdata;
                            r_data_le    <= !op_is_write(req_op);
                            r_data_we    <= op_is_write(req_op);
                        end else begin
                            r_dram_addr  <= req_addr;
                            r_dram_wdata <= req_wdata;
                            r_dram_ctrl  <= req_ctrl;
                            r_dram_le    <= !op_is_write(req_op);
                            r_dram_we    <= op_is_write(req_op);
                        end
                    end
                end
                ISSUE: begin
                    // Busy wins over expiry: the arbiter has taken the request.
                    if (w_sel_busy) begin
                        r_dram_le <= 1'b0;
                        r_dram_we <= 1'b0;
                        r_data_le <= 1'b0;
                        r_data_we <= 1'b0;
                        r_state   <= WAIT;
                    end else if (w_expired) begin
                        r_dram_le   <= 1'b0;
                        r_dram_we   <= 1'b0;
                        r_data_le   <= 1'b0;
                        r_data_we   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        r_state     <= RESP;
                    end
                end
                WAIT: begin
                    if (!w_sel_busy) begin
                        if (r_op == OP_DRAM_RD) begin
                            r_rsp_rdata <= bus_dram_odata;
                        end else if (r_op == OP_DATA_RD) begin
                            r_rsp_rdata <= bus_data_data;
                        end
                        r_rsp_valid <= 1'b1;
                        r_state     <= RESP;
                    end else if (w_expired) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        r_state     <= RESP;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign req_ready      = w_req_ready;
    assign rsp_valid      = r_rsp_valid;
    assign rsp_rdata      = r_rsp_rdata;
    assign rsp_err        = r_rsp_err;
    assign bus_dram_le    = r_dram_le;
    assign bus_dram_we_t  = r_dram_we;
    assign bus_dram_addr  = r_dram_addr;
    assign bus_dram_wdata = r_dram_wdata;
    assign bus_dram_ctrl  = r_dram_ctrl;
    assign bus_data_le    = r_data_le;
    assign bus_data_we    = r_data_we;
    assign bus_mem_paddr  = r_data_paddr;
    assign bus_data_wdata = r_data_wdata;

endmodule
`default_nettype wire

// File: tb/tb_core_bus_initiator.sv
`default_nettype none
// ============================================================================
// Module      : tb_core_bus_initiator
// Description : Directed self-checking bench for core_bus_initiator with a
//               small registered arbiter model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_core_bus_initiator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'b00;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [2:0]  req_ctrl = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        bus_dram_le;
    logic        bus_dram_we_t;
    logic [31:0] bus_dram_addr;
    logic [31:0] bus_dram_wdata;
    logic [2:0]  bus_dram_ctrl;
    logic        bus_dram_busy;
    logic [31:0] bus_dram_odata;
    logic        bus_data_le;
    logic        bus_data_we;
    logic [31:0] bus_mem_paddr;
    logic [31:0] bus_data_wdata;
    logic [3:0]  bus_data_busy;
    logic [31:0] bus_data_data;

    // Arbiter model state
    logic        arb_auto = 1'b1;
    int          arb_hold = 3;
    logic [31:0] arb_rdata = '0;
    logic        ext_dram_busy = 1'b0;
    logic        arb_dram_busy = 1'b0;
    logic [3:0]  arb_data_busy = 4'h0;
    logic [31:0] arb_dram_odata = '0;
    logic [31:0] arb_data_rdata = '0;
    int          dram_cnt = 0;
    int          data_cnt = 0;
    logic        overlap_any = 1'b0;

    int n_total = 0;
    int n_bad = 0;

    int          ro_wait;
    int          ro_strobes;
    int          ro_lat;
    logic [3:0]  ro_mask;
    logic        ro_addr_ok;
    int          n_wait;

    always #5 clk = ~clk;

    assign bus_dram_busy  = arb_dram_busy | ext_dram_busy;
    assign bus_data_busy  = arb_data_busy;
    assign bus_dram_odata = arb_dram_odata;
    assign bus_data_data  = arb_data_rdata;

    core_bus_initiator #(
        .TIMEOUT (8)
    ) dut (
        .CLK            (clk),
        .RST_X          (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_op         (req_op),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_ctrl       (req_ctrl),
        .rsp_valid      (rsp_valid),
        .rsp_rdata      (rsp_rdata),
        .rsp_err        (rsp_err),
        .bus_dram_le    (bus_dram_le),
        .bus_dram_we_t  (bus_dram_we_t),
        .bus_dram_addr  (bus_dram_addr),
        .bus_dram_wdata (bus_dram_wdata),
        .bus_dram_ctrl  (bus_dram_ctrl),
        .bus_dram_busy  (bus_dram_busy),
        .bus_dram_odata (bus_dram_odata),
        .bus_data_le    (bus_data_le),
        .bus_data_we    (bus_data_we),
        .bus_mem_paddr  (bus_mem_paddr),
        .bus_data_wdata (bus_data_wdata),
        .bus_data_busy  (bus_data_busy),
        .bus_data_data  (bus_data_data)
    );

    // Registered arbiter: busy rises the edge after a strobe, stays high arb_hold cycles.
    always @(posedge clk) begin
        if (arb_auto) begin
            if (dram_cnt == 0) begin
                if (bus_dram_le || bus_dram_we_t) begin
                    arb_dram_busy <= 1'b1;
                    dram_cnt      <= arb_hold;
                end
            end else if (dram_cnt == 1) begin
                arb_dram_busy  <= 1'b0;
                dram_cnt       <= 0;
                arb_dram_odata <= arb_rdata;
            end else begin
                dram_cnt <= dram_cnt - 1;
            end
            if (data_cnt == 0) begin
                if (bus_data_le || bus_data_we) begin
                    arb_data_busy <= 4'h1;
                    data_cnt      <= arb_hold;
                end
            end else if (data_cnt == 1) begin
                arb_data_busy  <= 4'h0;
                data_cnt       <= 0;
                arb_data_rdata <= arb_rdata;
            end else begin
                data_cnt <= data_cnt - 1;
            end
        end
    end

    always @(negedge clk) begin
        if ($countones({bus_dram_le, bus_dram_we_t, bus_data_le, bus_data_we}) > 1)
            overlap_any <= 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request, wait for acceptance, then watch until rsp_valid.
    task automatic run_op(input logic [1:0] op, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [2:0] ctrl,
                          input logic [31:0] rdata, input int hold);
        logic acc;
        arb_rdata = rdata;
        arb_hold  = hold;
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wdata;
        req_ctrl  = ctrl;
        ro_wait   = 0;
        acc       = 1'b0;
        while (!acc && ro_wait < 20) begin
            #1;
            acc = req_ready;
            tick();
            ro_wait++;
        end
        req_valid  = 1'b0;
        ro_strobes = 0;
        ro_lat     = -1;
        ro_mask    = '0;
        ro_addr_ok = 1'b1;
        for (int k = 0; k < 40 && ro_lat < 0; k++) begin
            if (k > 0) tick();
            ro_mask = ro_mask | {bus_dram_le, bus_dram_we_t, bus_data_le, bus_data_we};
            if (bus_dram_le || bus_dram_we_t || bus_data_le || bus_data_we) ro_strobes++;
            if (op[1]) begin
                if (bus_mem_paddr !== addr || bus_data_wdata !== wdata) ro_addr_ok = 1'b0;
            end else if (bus_dram_addr !== addr || bus_dram_wdata !== wdata) begin
                ro_addr_ok = 1'b0;
            end
            if (rsp_valid) ro_lat = k;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        tick();
        chk("rst_strobes", {28'd0, bus_dram_le, bus_dram_we_t, bus_data_le, bus_data_we}, 32'd0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_err", rsp_err, 1'b0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_dram_addr", bus_dram_addr, 32'd0);
        chk("rst_paddr", bus_mem_paddr, 32'd0);
        chk("rst_ready", req_ready, 1'b1);
        rst = 1'b0;

        // DRAM read against a 3-cycle-busy arbiter
        run_op(2'b00, 32'h8000_0100, 32'h0, 3'b010, 32'hDEAD_BEEF, 3);
        chk("t1_strobe_cycles", ro_strobes, 32'd2);
        chk("t1_latency", ro_lat, 32'd5);
        chk("t1_mask", {28'd0, ro_mask}, 32'h8);
        chk("t1_addr_stable", ro_addr_ok, 1'b1);
        chk("t1_ctrl", {29'd0, bus_dram_ctrl}, 32'd2);
        chk("t1_rdata", rsp_rdata, 32'hDEAD_BEEF);
        chk("t1_err", rsp_err, 1'b0);
        tick();
        chk("t1_pulse_end", rsp_valid, 1'b0);

        // Data write; read result must be untouched
        run_op(2'b11, 32'h1000_0000, 32'h41, 3'b000, 32'h0BAD_0BAD, 3);
        chk("t2_strobe_cycles", ro_strobes, 32'd2);
        chk("t2_latency", ro_lat, 32'd5);
        chk("t2_mask", {28'd0, ro_mask}, 32'h1);
        chk("t2_addr_stable", ro_addr_ok, 1'b1);
        chk("t2_rdata_kept", rsp_rdata, 32'hDEAD_BEEF);
        chk("t2_err", rsp_err, 1'b0);
        chk("t2_dram_addr_kept", bus_dram_addr, 32'h8000_0100);
        tick();

        // External DRAM busy blocks acceptance
        ext_dram_busy = 1'b1;
        req_valid = 1'b1;
        req_op    = 2'b00;
        req_addr  = 32'h8000_0200;
        req_ctrl  = 3'b001;
        #1;
        chk("t3_ready_blocked", req_ready, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t3_no_strobe", {28'd0, bus_dram_le, bus_dram_we_t, bus_data_le, bus_data_we}, 32'd0);
        end
        ext_dram_busy = 1'b0;
        #1;
        chk("t3_ready_released", req_ready, 1'b1);
        run_op(2'b00, 32'h8000_0200, 32'h0, 3'b001, 32'hCAFE_0003, 1);
        chk("t3_accept_wait", ro_wait, 32'd1);
        chk("t3_latency", ro_lat, 32'd3);
        chk("t3_strobe_cycles", ro_strobes, 32'd2);
        chk("t3_rdata", rsp_rdata, 32'hCAFE_0003);
        chk("t3_ctrl", {29'd0, bus_dram_ctrl}, 32'd1);
        tick();

        // Timeout with an arbiter that never answers
        arb_auto = 1'b0;
        run_op(2'b10, 32'h2000_0000, 32'h0, 3'b000, 32'h1111_1111, 3);
        chk("t4_strobe_cycles", ro_strobes, 32'd8);
        chk("t4_latency", ro_lat, 32'd8);
        chk("t4_mask", {28'd0, ro_mask}, 32'h2);
        chk("t4_err", rsp_err, 1'b1);
        chk("t4_rdata_kept", rsp_rdata, 32'hCAFE_0003);
        tick();
        chk("t4_pulse_end", rsp_valid, 1'b0);
        chk("t4_err_clear", rsp_err, 1'b0);
        arb_auto = 1'b1;

        // Reset while waiting on a long busy
        arb_hold  = 6;
        req_valid = 1'b1;
        req_op    = 2'b01;
        req_addr  = 32'h8000_0300;
        req_wdata = 32'h77;
        req_ctrl  = 3'b000;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        chk("t5_wait_strobe_low", bus_dram_we_t, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_strobes", {28'd0, bus_dram_le, bus_dram_we_t, bus_data_le, bus_data_we}, 32'd0);
        chk("t5_rsp_valid", rsp_valid, 1'b0);
        chk("t5_rdata_reset", rsp_rdata, 32'd0);
        chk("t5_dram_addr_reset", bus_dram_addr, 32'd0);
        chk("t5_ready_low", req_ready, 1'b0);
        n_wait = 0;
        while (!req_ready && n_wait < 20) begin
            tick();
            n_wait++;
        end
        chk("t5_ready_delay", n_wait, 32'd4);
        run_op(2'b10, 32'h3000_0000, 32'h0, 3'b000, 32'h1234_5678, 2);
        chk("t5_latency", ro_lat, 32'd4);
        chk("t5_rdata", rsp_rdata, 32'h1234_5678);
        chk("t5_err", rsp_err, 1'b0);
        tick();

        // Back-to-back: second request queued during the first response
        run_op(2'b01, 32'h8000_0400, 32'h55, 3'b011, 32'h0, 2);
        chk("t6a_latency", ro_lat, 32'd4);
        chk("t6a_mask", {28'd0, ro_mask}, 32'h4);
        chk("t6a_rdata_kept", rsp_rdata, 32'h1234_5678);
        run_op(2'b10, 32'h1000_0010, 32'h0, 3'b000, 32'hA5A5_5A5A, 1);
        chk("t6b_accept_wait", ro_wait, 32'd2);
        chk("t6b_latency", ro_lat, 32'd3);
        chk("t6b_mask", {28'd0, ro_mask}, 32'h2);
        chk("t6b_rdata", rsp_rdata, 32'hA5A5_5A5A);
        tick();

        chk("no_strobe_overlap", overlap_any, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
